// File: rtl/da_mac_engine.sv
// da_mac_engine: bit-serial distributed-arithmetic multiply-accumulate.
// One signed result per block of N_IN samples, MSB bit-plane first.
module da_mac_engine #(
    parameter  int IN_W   = 8,
    parameter  int N_IN   = 8,
    parameter  int ADDR_W = 4,
    parameter  int ROM_W  = 17,
    parameter  int SIGNED = 1,
    localparam int NB     = N_IN / ADDR_W,
    localparam int SW     = ROM_W + $clog2(NB),
    localparam int OUT_W  = SW + IN_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N_IN*IN_W-1:0]    in_data,
    output logic [NB*ADDR_W-1:0]    rom_addr,
    input  logic [NB*ROM_W-1:0]     rom_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    busy
);

    localparam int CW = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam int NX = (IN_W > 1) ? IN_W - 2 : 0;

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    state_t                   state;
    logic [IN_W-1:0]          sr [N_IN];
    logic [CW-1:0]            bitcnt;
    logic signed [OUT_W-1:0]  acc;
    logic signed [OUT_W-1:0]  acc_next;
    logic signed [OUT_W-1:0]  term;
    logic signed [SW-1:0]     psum;
    logic [NB*ADDR_W-1:0]     addr_q;
    logic [NB*ADDR_W-1:0]     addr_ld;
    logic [NB*ADDR_W-1:0]     addr_nx;
    logic                     accept;

    assign in_ready = (state == IDLE) || ((state == HOLD) && out_ready);
    assign accept   = in_valid && in_ready;
    assign rom_addr = addr_q;

    // Sum of all bank words for the current plane, sign-extended.
    always_comb begin
        psum = '0;
        for (int j = 0; j < NB; j++) begin
            psum = psum + SW'($signed(rom_data[j*ROM_W +: ROM_W]));
        end
    end

    // Shift-and-add; the sign plane is subtracted for two's-complement input.
    always_comb begin
        term = OUT_W'(psum);
        if ((SIGNED != 0) && (bitcnt == CW'(IN_W - 1))) begin
            term = -term;
        end
        acc_next = (acc <<< 1) + term;
    end

    // Bank addresses: lowest-index sample of a bank drives the address MSB.
    always_comb begin
        addr_ld = '0;
        addr_nx = '0;
        for (int j = 0; j < NB; j++) begin
            for (int i = 0; i < ADDR_W; i++) begin
                addr_ld[j*ADDR_W + ADDR_W-1-i] =
                    in_data[(j*ADDR_W + i)*IN_W + IN_W-1];
                addr_nx[j*ADDR_W + ADDR_W-1-i] = sr[j*ADDR_W + i][NX];
            end
        end
    end

    // Sequencer: accept a block, run IN_W planes, hold the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
            acc       <= '0;
            bitcnt    <= '0;
            addr_q    <= '0;
            for (int k = 0; k < N_IN; k++) sr[k] <= '0;
        end else if (accept) begin
            state     <= RUN;
            out_valid <= 1'b0;
            busy      <= 1'b1;
            acc       <= '0;
            bitcnt    <= CW'(IN_W - 1);
            addr_q    <= addr_ld;
            for (int k = 0; k < N_IN; k++) sr[k] <= in_data[k*IN_W +: IN_W];
        end else begin
            case (state)
                RUN: begin
                    acc <= acc_next;
                    for (int k = 0; k < N_IN; k++) sr[k] <= sr[k] << 1;
                    if (bitcnt == '0) begin
                        out_data  <= acc_next;
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        addr_q    <= '0;
                        state     <= HOLD;
                    end else begin
                        bitcnt <= bitcnt - 1'b1;
                        addr_q <= addr_nx;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_da_mac_engine.sv
// tb_da_mac_engine: four builds (signed NB=2, unsigned, NB=4, NB=1) run in
// lockstep from one stimulus stream; each has its own result queue.
module tb_da_mac_engine;

    logic clk = 1'b0;
    logic rst_n;
    logic in_valid;
    logic out_ready;
    logic [63:0] in_data;

    logic a_in_ready, a_ov, a_busy;
    logic [7:0] a_addr;
    logic [33:0] a_rom;
    logic signed [25:0] a_out;

    logic b_in_ready, b_ov, b_busy;
    logic [7:0] b_addr;
    logic [33:0] b_rom;
    logic signed [25:0] b_out;

    logic c_in_ready, c_ov, c_busy;
    logic [7:0] c_addr;
    logic [67:0] c_rom;
    logic signed [26:0] c_out;

    logic d_in_ready, d_ov, d_busy;
    logic [3:0] d_addr;
    logic [16:0] d_rom;
    logic signed [24:0] d_out;

    int coef [8];
    int vec = 0;
    int bad = 0;
    int accepted = 0;
    longint qa[$], qb[$], qc[$], qd[$];

    localparam logic [63:0] ONES = 64'h0101010101010101;
    localparam logic [63:0] M128 = 64'h8080808080808080;
    localparam logic [63:0] ALLF = 64'hFFFFFFFFFFFFFFFF;
    localparam logic [63:0] MIX  = 64'h02802100C405FF7F;

    always #5 clk = ~clk;

    da_mac_engine dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_data(in_data), .rom_addr(a_addr), .rom_data(a_rom),
        .out_valid(a_ov), .out_ready(out_ready), .out_data(a_out), .busy(a_busy)
    );

    da_mac_engine #(.SIGNED(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_data(in_data), .rom_addr(b_addr), .rom_data(b_rom),
        .out_valid(b_ov), .out_ready(out_ready), .out_data(b_out), .busy(b_busy)
    );

    da_mac_engine #(.ADDR_W(2)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(c_in_ready),
        .in_data(in_data), .rom_addr(c_addr), .rom_data(c_rom),
        .out_valid(c_ov), .out_ready(out_ready), .out_data(c_out), .busy(c_busy)
    );

    da_mac_engine #(.N_IN(4)) dut_d (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(d_in_ready),
        .in_data(in_data[31:0]), .rom_addr(d_addr), .rom_data(d_rom),
        .out_valid(d_ov), .out_ready(out_ready), .out_data(d_out), .busy(d_busy)
    );

    // DA ROM contents: partial sum of the coefficients whose address bit is set.
    function automatic int rom_val(input int a, input int base, input int aw);
        int v;
        v = 0;
        for (int i = 0; i < aw; i++) begin
            if (a[aw-1-i]) v += coef[base+i];
        end
        return v;
    endfunction

    // Golden block result: sum of c_k * x_k over the first n samples.
    function automatic longint gold(input logic [63:0] x, input int n,
                                    input bit sgn);
        longint s;
        logic [7:0] b;
        longint v;
        s = 0;
        for (int k = 0; k < n; k++) begin
            b = x[k*8 +: 8];
            v = sgn ? longint'($signed(b)) : longint'(b);
            s += longint'(coef[k]) * v;
        end
        return s;
    endfunction

    // Combinational ROM models for each build.
    always_comb begin
        a_rom = '0;
        b_rom = '0;
        c_rom = '0;
        for (int j = 0; j < 2; j++) begin
            a_rom[j*17 +: 17] = 17'(rom_val(int'(a_addr[j*4 +: 4]), j*4, 4));
            b_rom[j*17 +: 17] = 17'(rom_val(int'(b_addr[j*4 +: 4]), j*4, 4));
        end
        for (int j = 0; j < 4; j++) begin
            c_rom[j*17 +: 17] = 17'(rom_val(int'(c_addr[j*2 +: 2]), j*2, 2));
        end
        d_rom = 17'(rom_val(int'(d_addr), 0, 4));
    end

    // Scoreboard: pop on result handshake, push on block handshake.
    always @(negedge clk) begin
        longint e;
        if (rst_n) begin
            if (a_ov && out_ready) begin
                vec++;
                if (qa.size() == 0) begin
                    bad++;
                    $display("FAIL sb_a: got %0d with empty queue", a_out);
                end else begin
                    e = qa.pop_front();
                    if (longint'(a_out) !== e) begin
                        bad++;
                        $display("FAIL sb_a: got %0d expected %0d", a_out, e);
                    end
                end
            end
            if (b_ov && out_ready) begin
                vec++;
                if (qb.size() == 0) begin
                    bad++;
                    $display("FAIL sb_b: got %0d with empty queue", b_out);
                end else begin
                    e = qb.pop_front();
                    if (longint'(b_out) !== e) begin
                        bad++;
                        $display("FAIL sb_b: got %0d expected %0d", b_out, e);
                    end
                end
            end
            if (c_ov && out_ready) begin
                vec++;
                if (qc.size() == 0) begin
                    bad++;
                    $display("FAIL sb_c: got %0d with empty queue", c_out);
                end else begin
                    e = qc.pop_front();
                    if (longint'(c_out) !== e) begin
                        bad++;
                        $display("FAIL sb_c: got %0d expected %0d", c_out, e);
                    end
                end
            end
            if (d_ov && out_ready) begin
                vec++;
                if (qd.size() == 0) begin
                    bad++;
                    $display("FAIL sb_d: got %0d with empty queue", d_out);
                end else begin
                    e = qd.pop_front();
                    if (longint'(d_out) !== e) begin
                        bad++;
                        $display("FAIL sb_d: got %0d expected %0d", d_out, e);
                    end
                end
            end
            if (in_valid && a_in_ready) begin
                qa.push_back(gold(in_data, 8, 1'b1));
                qb.push_back(gold(in_data, 8, 1'b0));
                qc.push_back(gold(in_data, 8, 1'b1));
                qd.push_back(gold(in_data, 4, 1'b1));
                accepted++;
            end
        end
    end

    // Present a block until accepted; returns one step after the accept edge.
    task automatic send(input logic [63:0] x);
        int n;
        bit ok;
        n = 0;
        ok = 1'b0;
        in_data = x;
        in_valid = 1'b1;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = a_in_ready;
            @(posedge clk) #1;
            n++;
        end
        in_valid = 1'b0;
        if (!ok) begin
            vec++;
            bad++;
            $display("FAIL send: block not accepted within %0d cycles", n);
        end
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!a_ov && n < 40) begin
            @(posedge clk) #1;
            n++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        in_data = '0;
        #1;
        vec++;
        if (a_in_ready !== 1'b1 || a_ov !== 1'b0 || a_busy !== 1'b0 ||
            a_out !== '0 || a_addr !== '0) begin
            bad++;
            $display("FAIL reset: rdy=%b ov=%b busy=%b out=%0d addr=%h need 1 0 0 0 0",
                     a_in_ready, a_ov, a_busy, a_out, a_addr);
        end
        @(posedge clk) #3;
        rst_n = 1'b1;
        @(posedge clk) #1;
    endtask

    task automatic test_basic;
        int n;
        send(ONES);
        wait_out(n);
        vec++;
        if (n != 8) begin
            bad++;
            $display("FAIL latency: got %0d cycles need 8", n);
        end
        vec++;
        if (a_out !== 26'sd8 || b_out !== 26'sd8 || c_out !== 27'sd8 ||
            d_out !== 25'sd4) begin
            bad++;
            $display("FAIL ones: got %0d %0d %0d %0d need 8 8 8 4",
                     a_out, b_out, c_out, d_out);
        end
        @(posedge clk) #1;
        vec++;
        if (a_ov !== 1'b0 || a_in_ready !== 1'b1) begin
            bad++;
            $display("FAIL to_idle: ov=%b rdy=%b need 0 1", a_ov, a_in_ready);
        end
    endtask

    task automatic test_signed;
        int n;
        send(M128);
        vec++;
        if (a_addr !== 8'hFF) begin
            bad++;
            $display("FAIL sign_plane_addr: got %h need ff", a_addr);
        end
        @(posedge clk) #1;
        vec++;
        if (a_addr !== 8'h00) begin
            bad++;
            $display("FAIL plane6_addr: got %h need 00", a_addr);
        end
        wait_out(n);
        vec++;
        if (a_out !== -26'sd1024 || b_out !== 26'sd1024 || d_out !== -25'sd512) begin
            bad++;
            $display("FAIL m128: got %0d %0d %0d need -1024 1024 -512",
                     a_out, b_out, d_out);
        end
        @(posedge clk) #1;
        send(MIX);
        wait_out(n);
        vec++;
        if (a_out !== -26'sd22 || b_out !== 26'sd746 || c_out !== -27'sd22 ||
            d_out !== 25'sd71) begin
            bad++;
            $display("FAIL mixed: got %0d %0d %0d %0d need -22 746 -22 71",
                     a_out, b_out, c_out, d_out);
        end
        @(posedge clk) #1;
    endtask

    task automatic test_unsigned;
        send(ALLF);
        for (int i = 0; i < 8; i++) begin
            vec++;
            if (b_addr[3:0] !== 4'hF) begin
                bad++;
                $display("FAIL u_addr plane %0d: got %h need f", 7 - i, b_addr[3:0]);
            end
            @(posedge clk) #1;
        end
        vec++;
        if (b_ov !== 1'b1 || b_out !== 26'sd2040 || a_out !== -26'sd8) begin
            bad++;
            $display("FAIL unsigned: ov=%b got %0d %0d need 1 2040 -8",
                     b_ov, b_out, a_out);
        end
        vec++;
        if (b_addr !== 8'h00) begin
            bad++;
            $display("FAIL addr_hold: got %h need 00", b_addr);
        end
        @(posedge clk) #1;
    endtask

    task automatic test_backpressure;
        int n;
        logic signed [25:0] held;
        send({$urandom, $urandom});
        wait_out(n);
        out_ready = 1'b0;
        in_data = MIX;
        in_valid = 1'b1;
        held = a_out;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk) #1;
            vec++;
            if (a_out !== held || a_in_ready !== 1'b0 || a_ov !== 1'b1 ||
                a_busy !== 1'b0) begin
                bad++;
                $display("FAIL hold %0d: out=%0d rdy=%b ov=%b busy=%b need %0d 0 1 0",
                         i, a_out, a_in_ready, a_ov, a_busy, held);
            end
        end
        out_ready = 1'b1;
        #1;
        vec++;
        if (a_in_ready !== 1'b1) begin
            bad++;
            $display("FAIL release_ready: got %b need 1", a_in_ready);
        end
        @(posedge clk) #1;
        in_valid = 1'b0;
        vec++;
        if (a_busy !== 1'b1 || a_ov !== 1'b0) begin
            bad++;
            $display("FAIL same_edge_accept: busy=%b ov=%b need 1 0", a_busy, a_ov);
        end
        wait_out(n);
        vec++;
        if (n != 8 || a_out !== -26'sd22) begin
            bad++;
            $display("FAIL bp_result: %0d cycles value %0d need 8 -22", n, a_out);
        end
        @(posedge clk) #1;
    endtask

    task automatic test_reset_mid;
        int n;
        send({$urandom, $urandom});
        repeat (4) @(posedge clk);
        #2;
        vec++;
        if (a_busy !== 1'b1) begin
            bad++;
            $display("FAIL pre_abort_busy: got %b need 1", a_busy);
        end
        rst_n = 1'b0;
        #1;
        vec++;
        if (a_in_ready !== 1'b1 || a_ov !== 1'b0 || a_busy !== 1'b0 ||
            a_out !== '0 || a_addr !== '0 || c_busy !== 1'b0) begin
            bad++;
            $display("FAIL async_abort: rdy=%b ov=%b busy=%b out=%0d addr=%h",
                     a_in_ready, a_ov, a_busy, a_out, a_addr);
        end
        qa.delete();
        qb.delete();
        qc.delete();
        qd.delete();
        @(posedge clk) #3;
        rst_n = 1'b1;
        @(posedge clk) #1;
        send(MIX);
        wait_out(n);
        vec++;
        if (n != 8 || a_out !== -26'sd22 || d_out !== 25'sd71) begin
            bad++;
            $display("FAIL post_reset: %0d cycles %0d %0d need 8 -22 71",
                     n, a_out, d_out);
        end
        @(posedge clk) #1;
    endtask

    task automatic drain;
        int n;
        n = 0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        while ((qa.size() != 0 || a_busy || a_ov) && n < 100) begin
            @(posedge clk) #1;
            n++;
        end
        if (n >= 100) begin
            vec++;
            bad++;
            $display("FAIL drain: pipeline not empty after %0d cycles", n);
        end
    endtask

    task automatic test_random;
        int target;
        int cyc;
        bit took;
        for (int ep = 0; ep < 4; ep++) begin
            drain();
            for (int k = 0; k < 8; k++) coef[k] = int'($urandom_range(0, 16382)) - 8191;
            target = accepted + 250;
            cyc = 0;
            in_valid = 1'b0;
            while (accepted < target && cyc < 8000) begin
                @(negedge clk);
                took = in_valid && a_in_ready;
                @(posedge clk) #1;
                cyc++;
                if (took || !in_valid) begin
                    in_valid = ($urandom_range(0, 3) != 0);
                    in_data = {$urandom, $urandom};
                end
                out_ready = ($urandom_range(0, 3) != 0);
            end
            in_valid = 1'b0;
            if (cyc >= 8000) begin
                vec++;
                bad++;
                $display("FAIL random epoch %0d: only %0d blocks accepted", ep, accepted);
            end
        end
        drain();
    endtask

    initial begin
        for (int k = 0; k < 8; k++) coef[k] = 1;
        test_reset();
        test_basic();
        test_signed();
        test_unsigned();
        test_backpressure();
        test_reset_mid();
        test_random();
        vec++;
        if (qa.size() != 0 || qb.size() != 0 || qc.size() != 0 || qd.size() != 0) begin
            bad++;
            $display("FAIL leftover: queues %0d %0d %0d %0d need all 0",
                     qa.size(), qb.size(), qc.size(), qd.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

endmodule
